// File: rtl/jpeg_pkg.sv
// Shared constants and pack-state enum for the JPEG entropy-coder bit packer.
package jpeg_pkg;

    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_EOI           = 8'hD9;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PAD,
        ST_DRAIN,
        ST_EOI_FF,
        ST_EOI_D9,
        ST_DONE
    } pack_state_e;

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// One-byte output register: follows every non-raw 0xFF with an inserted 0x00,
// holding its byte stable under backpressure.
module jpeg_byte_stuffer
    import jpeg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       load_raw,
    output logic       can_load,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte
);

    logic       valid_q, valid_d;
    logic [7:0] byte_q, byte_d;
    logic       stuff_q, stuff_d;
    logic       handoff;

    always_comb begin
        handoff  = valid_q && out_ready;
        can_load = !valid_q || (handoff && !stuff_q);
        valid_d  = valid_q;
        byte_d   = byte_q;
        stuff_d  = stuff_q;
        // A pending 0x00 takes priority over any new load.
        if (handoff && stuff_q) begin
            valid_d = 1'b1;
            byte_d  = JPEG_STUFF_BYTE;
            stuff_d = 1'b0;
        end else if (load && can_load) begin
            valid_d = 1'b1;
            byte_d  = load_byte;
            stuff_d = !load_raw && (load_byte == JPEG_MARKER_PREFIX);
        end else if (handoff) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            byte_q  <= '0;
            stuff_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            byte_q  <= byte_d;
            stuff_q <= stuff_d;
        end
    end

    assign out_valid = valid_q;
    assign out_byte  = byte_q;

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs right-justified Huffman codes MSB-first into a byte-stuffed JPEG stream.
// Define JPEG_PACK_EOI_EN to append the 0xFF,0xD9 EOI marker after each flush.
module jpeg_bit_packer
    import jpeg_pkg::*;
#(
    parameter int unsigned CODE_W = 16,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              flush_done
);

    localparam int unsigned      CNT_W     = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACC_W - CODE_W);
    localparam logic [CNT_W-1:0] CNT_BYTE  = CNT_W'(8);

    pack_state_e      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             extract;
    logic [ACC_W-1:0] ones;
    logic [2:0]       pad_len;
    logic             st_load;
    logic             st_raw;
    logic             st_can_load;
    logic [7:0]       st_byte;

    jpeg_byte_stuffer u_stuffer (
        .clk       (clk),
        .rst       (rst),
        .load      (st_load),
        .load_byte (st_byte),
        .load_raw  (st_raw),
        .can_load  (st_can_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (flush && in_ready) state_d = ST_PAD;
            ST_PAD:   state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0 && !out_valid) begin
`ifdef JPEG_PACK_EOI_EN
                state_d = ST_EOI_FF;
`else
                state_d = ST_DONE;
`endif
            end
`ifdef JPEG_PACK_EOI_EN
            ST_EOI_FF: if (out_valid && out_ready) state_d = ST_EOI_D9;
            ST_EOI_D9: if (out_valid && out_ready) state_d = ST_DONE;
`endif
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        in_ready   = !rst && (state_q == ST_RUN) && (cnt_q <= CNT_LIMIT);
        flush_done = (state_q == ST_DONE);
        st_load    = extract;
        st_byte    = 8'(acc_q >> (cnt_q - CNT_BYTE));
        st_raw     = 1'b0;
`ifdef JPEG_PACK_EOI_EN
        // Marker bytes go in raw once the stuffer is empty; state advances on their handoff.
        if (state_q == ST_EOI_FF || state_q == ST_EOI_D9) begin
            st_load = !out_valid;
            st_byte = (state_q == ST_EOI_FF) ? JPEG_MARKER_PREFIX : JPEG_EOI;
            st_raw  = 1'b1;
        end
`endif
    end

    always_comb begin
        ones    = '1;
        accept  = in_valid && in_ready;
        extract = (cnt_q >= CNT_BYTE) && st_can_load;
        pad_len = 3'd0 - cnt_q[2:0];
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (state_q == ST_DONE) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            // Bits above cnt are stale; extraction indexes from cnt, so they never need clearing.
            if (accept) begin
                acc_d = (acc_q << in_len) | (ACC_W'(in_code) & ~(ones << in_len));
                cnt_d = cnt_q + CNT_W'(in_len);
            end else if (state_q == ST_PAD) begin
                acc_d = (acc_q << pad_len) | ~(ones << pad_len);
                cnt_d = cnt_q + CNT_W'(pad_len);
            end
            if (extract) cnt_d = cnt_d - CNT_BYTE;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer: directed cases plus random beats scored
// against a bit-queue reference model.
`timescale 1ns/1ps
module tb_jpeg_bit_packer;

    localparam int unsigned CODE_W = 16;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ACC_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic [LEN_W-1:0]  in_len;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_byte;
    logic              flush_done;

    jpeg_bit_packer #(.CODE_W(CODE_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_len     (in_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    bit         bits_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         flush_pending = 1'b0;
    int         done_seen = 0;
    int         beats_acc = 0;
    bit         hold_v = 1'b0;
    logic [7:0] hold_b = 8'h00;
    bit         rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_bytes();
        while (bits_q.size() >= 8) begin
            logic [7:0] b;
            for (int i = 0; i < 8; i++) b = {b[6:0], bits_q.pop_front()};
            exp_q.push_back(b);
            if (b == 8'hFF) exp_q.push_back(8'h00);
        end
    endtask

    task automatic model_push(input logic [CODE_W-1:0] c, input logic [LEN_W-1:0] l);
        for (int i = int'(l) - 1; i >= 0; i--) bits_q.push_back(c[i]);
        model_bytes();
    endtask

    task automatic model_flush();
        while (bits_q.size() % 8 != 0) bits_q.push_back(1'b1);
        model_bytes();
`ifdef JPEG_PACK_EOI_EN
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
`endif
        flush_pending = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) begin
            bits_q.delete();
            exp_q.delete();
            flush_pending = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (flush_pending) chk("in_ready_during_flush", 32'(in_ready), 32'(0));
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_byte", 32'(out_byte), 32'(hold_b));
            end
            hold_v = out_valid && !out_ready;
            hold_b = out_byte;
            if (out_valid && out_ready) begin
                got_q.push_back(out_byte);
                if (exp_q.size() == 0) chk("unexpected_byte", 32'(out_byte), 32'hDEAD);
                else chk("stream_byte", 32'(out_byte), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                beats_acc++;
                model_push(in_code, in_len);
            end
            if (flush && in_ready) model_flush();
            if (flush_done) begin
                chk("flush_done_pending", 32'(flush_pending), 32'(1));
                chk("flush_done_drained", 32'(exp_q.size()), 32'(0));
                flush_pending = 1'b0;
                done_seen++;
            end
        end
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [CODE_W-1:0] c, input logic [LEN_W-1:0] l);
        int b0 = beats_acc;
        in_valid = 1'b1;
        in_code  = c;
        in_len   = l;
        for (int k = 0; k < 1000 && beats_acc == b0; k++) tick();
        chk("beat_accept_timeout", 32'(beats_acc - b0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) tick();
        chk("drain_timeout", 32'(exp_q.size()), 32'(0));
        idle(3);
    endtask

    task automatic do_flush(input bit with_beat, input logic [CODE_W-1:0] c, input logic [LEN_W-1:0] l);
        int d0 = done_seen;
        flush    = 1'b1;
        in_valid = with_beat;
        in_code  = c;
        in_len   = l;
        for (int k = 0; k < 1000 && !flush_pending; k++) tick();
        chk("flush_accept_timeout", 32'(flush_pending), 32'(1));
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 2000 && done_seen == d0; k++) tick();
        chk("flush_done_timeout", 32'(done_seen - d0), 32'(1));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_byte", 32'(out_byte), 32'(0));
        chk("rst_flush_done", 32'(flush_done), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'(1));

        // Two codes forming one byte
        out_ready = 1'b1;
        got_q.delete();
        send_beat(16'h0005, 4'd3);
        send_beat(16'h001F, 4'd5);
        drain();
        chk("t1_count", 32'(got_q.size()), 32'(1));
        chk("t1_byte", 32'(got_q[0]), 32'hBF);

        // 0xFF is stuffed, following byte unaffected
        got_q.delete();
        send_beat(16'h00FF, 4'd8);
        send_beat(16'h0012, 4'd8);
        drain();
        chk("t2_count", 32'(got_q.size()), 32'(3));
        chk("t2_b0", 32'(got_q[0]), 32'hFF);
        chk("t2_b1", 32'(got_q[1]), 32'h00);
        chk("t2_b2", 32'(got_q[2]), 32'h12);

        // Flush pads with ones
        got_q.delete();
        send_beat(16'h0001, 4'd1);
        idle(1);
        do_flush(1'b0, '0, '0);
        drain();
        chk("t3_b0", 32'(got_q[0]), 32'hFF);
        chk("t3_b1", 32'(got_q[1]), 32'h00);
`ifdef JPEG_PACK_EOI_EN
        chk("t3_count", 32'(got_q.size()), 32'(4));
        chk("t3_b2", 32'(got_q[2]), 32'hFF);
        chk("t3_b3", 32'(got_q[3]), 32'hD9);
`else
        chk("t3_count", 32'(got_q.size()), 32'(2));
`endif

        // Backpressure: one byte held in the stuffer, accumulator stops at cnt > ACC_W-CODE_W
        begin
            int b0;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_code   = 16'h7FFF;
            in_len    = 4'd15;
            b0 = beats_acc;
            repeat (20) tick();
            chk("t4_in_ready_low", 32'(in_ready), 32'(0));
            chk("t4_beats_accepted", 32'(beats_acc - b0), 32'(2));
            out_ready = 1'b1;
            repeat (4) send_beat(16'h7FFF, 4'd15);
            drain();
            do_flush(1'b0, '0, '0);
            drain();
        end

        // Reset mid-stream discards everything
        got_q.delete();
        out_ready = 1'b0;
        send_beat(16'h0011, 4'd8);
        send_beat(16'h0022, 4'd8);
        send_beat(16'h0033, 4'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t5_out_valid", 32'(out_valid), 32'(0));
        out_ready = 1'b1;
        idle(5);
        chk("t5_no_residual", 32'(got_q.size()), 32'(0));
        send_beat(16'h00A5, 4'd8);
        drain();
        chk("t5_count", 32'(got_q.size()), 32'(1));
        chk("t5_byte", 32'(got_q[0]), 32'hA5);

        // Zero-length beats and masking of bits above in_len
        got_q.delete();
        send_beat(16'hFFFF, 4'd0);
        send_beat(16'hFFFC, 4'd4);
        send_beat(16'hABCD, 4'd0);
        send_beat(16'h1233, 4'd4);
        send_beat(16'h0001, 4'd0);
        drain();
        chk("t6_count", 32'(got_q.size()), 32'(1));
        chk("t6_byte", 32'(got_q[0]), 32'hC3);

        // Random beats with random downstream stalls, each round ended by a flush
        rand_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send_beat(CODE_W'($urandom), LEN_W'($urandom_range(0, 15)));
            end
            do_flush(1'((r % 2) == 1), CODE_W'($urandom), LEN_W'($urandom_range(0, 15)));
            drain();
        end
        rand_rdy = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
